// File: rtl/fft_peak_pkg.sv
// Shared constants and control-FSM state type for the FFT peak detector.
package fft_peak_pkg;

    localparam int FRAME_LEN_DEFAULT = 1024;
    localparam int BIN_W             = $clog2(FRAME_LEN_DEFAULT);
    localparam int MAG_W             = 65;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StFlush,
        StReport
    } state_e;

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage squared-magnitude pipeline: registered products, then registered sum.
module fft_mag_sq
    import fft_peak_pkg::*;
#(
    parameter int BIN_WIDTH = BIN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [BIN_WIDTH-1:0] in_bin,
    input  logic [31:0]          in_re,
    input  logic [31:0]          in_im,
    output logic                 out_valid,
    output logic [BIN_WIDTH-1:0] out_bin,
    output logic [MAG_W-1:0]     out_mag,
    output logic                 pipe_busy
);

    logic signed [63:0] re_ext, im_ext;
    logic signed [63:0] re_sq_q, im_sq_q;
    logic [BIN_WIDTH-1:0] bin1_q, bin2_q;
    logic [MAG_W-1:0]     mag_q;
    logic                 v1_q, v2_q;

    assign re_ext = 64'(signed'(in_re));
    assign im_ext = 64'(signed'(in_im));

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= in_valid;
            v2_q <= v1_q;
        end
    end

    // Squares are non-negative and at most 2^62, so the sum never overflows 65 bits.
    always_ff @(posedge clk) begin
        re_sq_q <= re_ext * re_ext;
        im_sq_q <= im_ext * im_ext;
        bin1_q  <= in_bin;
        mag_q   <= {1'b0, re_sq_q} + {1'b0, im_sq_q};
        bin2_q  <= bin1_q;
    end

    assign out_valid = v2_q;
    assign out_bin   = bin2_q;
    assign out_mag   = mag_q;
    assign pipe_busy = v1_q | v2_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame peak search over FFT output beats: counts bins, squares magnitudes and
// reports the largest in-range bin three cycles after the closing beat.
module fft_peak_detect
    import fft_peak_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
    parameter int START_BIN = 1,
    parameter int STOP_BIN  = 511
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [31:0]                  in_re,
    input  logic [31:0]                  in_im,
    output logic                         peak_valid,
    output logic [$clog2(FRAME_LEN)-1:0] peak_bin,
    output logic [MAG_W-1:0]             peak_mag,
    output logic                         busy
);

    localparam int BinW = $clog2(FRAME_LEN);
    localparam logic [BinW-1:0] LastBin = BinW'(FRAME_LEN - 1);

    state_e state_q, state_d;

    logic [BinW-1:0]  cnt_q;
    logic             close_beat;
    logic             mag_valid;
    logic [BinW-1:0]  mag_bin;
    logic [MAG_W-1:0] mag;
    logic             pipe_busy;
    logic             in_range;
    logic             mag_last;
    logic             have_q;
    logic             done_q;
    logic [MAG_W-1:0] max_mag_q;
    logic [BinW-1:0]  max_bin_q;
    logic [MAG_W-1:0] peak_mag_q;
    logic [BinW-1:0]  peak_bin_q;

    assign close_beat = in_valid && (cnt_q == LastBin);

    // Power-of-two frame length makes the natural counter rollover the frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (in_valid) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    fft_mag_sq #(
        .BIN_WIDTH(BinW)
    ) u_mag_sq (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_bin   (cnt_q),
        .in_re    (in_re),
        .in_im    (in_im),
        .out_valid(mag_valid),
        .out_bin  (mag_bin),
        .out_mag  (mag),
        .pipe_busy(pipe_busy)
    );

    assign in_range = (int'(mag_bin) >= START_BIN) && (int'(mag_bin) <= STOP_BIN);
    assign mag_last = mag_valid && (mag_bin == LastBin);

    // have_q marks that the running max holds a bin of the current frame; a clear
    // flag forces the first in-range bin to load even when its magnitude is zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            have_q    <= 1'b0;
            done_q    <= 1'b0;
            max_mag_q <= '0;
            max_bin_q <= '0;
        end else begin
            done_q <= mag_last;
            if (mag_valid && in_range && (!have_q || (mag > max_mag_q))) begin
                max_mag_q <= mag;
                max_bin_q <= mag_bin;
            end
            if (mag_valid) begin
                have_q <= mag_last ? 1'b0 : (have_q | in_range);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_mag_q <= '0;
            peak_bin_q <= '0;
        end else if (done_q) begin
            peak_mag_q <= max_mag_q;
            peak_bin_q <= max_bin_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = close_beat ? StFlush : StAcc;
                end
            end
            StAcc: begin
                if (close_beat) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (done_q) begin
                    state_d = StReport;
                end
            end
            StReport: begin
                // Beats of the next frame may already have arrived during the flush.
                state_d = ((cnt_q != '0) || in_valid) ? StAcc : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign peak_valid = (state_q == StReport);
    assign peak_bin   = peak_bin_q;
    assign peak_mag   = peak_mag_q;
    assign busy       = !((state_q == StIdle) && !pipe_busy && !done_q);

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: tone, tie/range, extremes, gaps, back-to-back, reset.
module tb_fft_peak_detect;

    localparam int FRAME_LEN = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_re = '0;
    logic [31:0] in_im = '0;
    logic        peak_valid;
    logic [9:0]  peak_bin;
    logic [64:0] peak_mag;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    int          re_tab[FRAME_LEN];
    int          im_tab[FRAME_LEN];
    int          pq_cyc[$];
    logic [9:0]  pq_bin[$];
    logic [64:0] pq_mag[$];

    fft_peak_detect #(
        .FRAME_LEN(FRAME_LEN),
        .START_BIN(1),
        .STOP_BIN (511)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .peak_valid(peak_valid),
        .peak_bin  (peak_bin),
        .peak_mag  (peak_mag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (peak_valid) begin
                pq_cyc.push_back(cyc);
                pq_bin.push_back(peak_bin);
                pq_mag.push_back(peak_mag);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < FRAME_LEN; i++) begin
            re_tab[i] = 0;
            im_tab[i] = 0;
        end
        pq_cyc.delete();
        pq_bin.delete();
        pq_mag.delete();
    endtask

    // Drives beats first..last from the tables; duty < 100 inserts random idle cycles.
    task automatic send_beats(input int first, input int last, input int duty,
                              output int close_cyc);
        close_cyc = -1;
        for (int b = first; b <= last; b++) begin
            if (duty < 100) begin
                while (int'($urandom_range(99)) >= duty) step(1);
            end
            in_valid = 1'b1;
            in_re    = re_tab[b];
            in_im    = im_tab[b];
            if (b == FRAME_LEN - 1) close_cyc = cyc + 1;
            step(1);
            in_valid = 1'b0;
            in_re    = '0;
            in_im    = '0;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_re    = 32'd777;
        step(3);
        n_total++;
        if (peak_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", peak_valid);
        else n_pass++;
        n_total++;
        if (peak_bin !== 10'd0) $display("FAIL reset_bin: got %0d want 0", peak_bin);
        else n_pass++;
        n_total++;
        if (peak_mag !== 65'd0) $display("FAIL reset_mag: got %0d want 0", peak_mag);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy);
        else n_pass++;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_re    = '0;
        step(2);
    endtask

    task automatic test_single_tone();
        int close_cyc;
        clear_all();
        re_tab[100] = 1000;
        im_tab[100] = -2000;
        send_beats(0, FRAME_LEN - 1, 100, close_cyc);
        n_total++;
        if (busy !== 1'b1) $display("FAIL tone_busy_flush: got %0b want 1", busy);
        else n_pass++;
        step(8);
        n_total++;
        if (pq_cyc.size() != 1) $display("FAIL tone_pulses: got %0d want 1", pq_cyc.size());
        else begin
            n_pass++;
            n_total++;
            if (pq_cyc[0] != close_cyc + 3)
                $display("FAIL tone_latency: got %0d want %0d", pq_cyc[0] - close_cyc, 3);
            else n_pass++;
            n_total++;
            if (pq_bin[0] !== 10'd100) $display("FAIL tone_bin: got %0d want 100", pq_bin[0]);
            else n_pass++;
            n_total++;
            if (pq_mag[0] !== 65'd5000000)
                $display("FAIL tone_mag: got %0d want 5000000", pq_mag[0]);
            else n_pass++;
        end
        n_total++;
        if (peak_bin !== 10'd100) $display("FAIL tone_hold: got %0d want 100", peak_bin);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL tone_busy_idle: got %0b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_tie_range();
        int close_cyc;
        clear_all();
        re_tab[0]   = 5;
        re_tab[40]  = 5;
        re_tab[700] = 5;
        send_beats(0, FRAME_LEN - 1, 100, close_cyc);
        step(8);
        n_total++;
        if (pq_cyc.size() != 1 || pq_bin[0] !== 10'd40 || pq_mag[0] !== 65'd25)
            $display("FAIL tie_range: got n=%0d bin=%0d mag=%0d want n=1 bin=40 mag=25",
                     pq_cyc.size(), peak_bin, peak_mag);
        else n_pass++;
        // Equal mag 25 via two different vectors: lower bin must win.
        clear_all();
        re_tab[300] = 5;
        re_tab[200] = -3;
        im_tab[200] = 4;
        send_beats(0, FRAME_LEN - 1, 100, close_cyc);
        step(8);
        n_total++;
        if (pq_cyc.size() != 1 || pq_bin[0] !== 10'd200 || pq_mag[0] !== 65'd25)
            $display("FAIL tie_low_bin: got n=%0d bin=%0d mag=%0d want n=1 bin=200 mag=25",
                     pq_cyc.size(), peak_bin, peak_mag);
        else n_pass++;
        // All-zero frame: first in-range bin loads unconditionally.
        clear_all();
        re_tab[0] = 9;
        send_beats(0, FRAME_LEN - 1, 100, close_cyc);
        step(8);
        n_total++;
        if (pq_cyc.size() != 1 || pq_bin[0] !== 10'd1 || pq_mag[0] !== 65'd0)
            $display("FAIL zero_frame: got n=%0d bin=%0d mag=%0d want n=1 bin=1 mag=0",
                     pq_cyc.size(), peak_bin, peak_mag);
        else n_pass++;
    endtask

    task automatic test_extremes();
        int close_cyc;
        logic [64:0] want;
        want = {2'b01, 63'd0};
        clear_all();
        re_tab[5] = 32'h8000_0000;
        im_tab[5] = 32'h8000_0000;
        send_beats(0, FRAME_LEN - 1, 100, close_cyc);
        step(8);
        n_total++;
        if (pq_cyc.size() != 1 || pq_bin[0] !== 10'd5 || pq_mag[0] !== want)
            $display("FAIL extremes: got n=%0d bin=%0d mag=%0h want n=1 bin=5 mag=%0h",
                     pq_cyc.size(), peak_bin, peak_mag, want);
        else n_pass++;
    endtask

    task automatic test_gapped();
        int close_cyc;
        clear_all();
        re_tab[257] = 12345;
        im_tab[257] = -678;
        send_beats(0, FRAME_LEN - 1, 30, close_cyc);
        step(8);
        n_total++;
        if (pq_cyc.size() != 1 || pq_bin[0] !== 10'd257 || pq_mag[0] !== 65'd152858709)
            $display("FAIL gapped: got n=%0d bin=%0d mag=%0d want n=1 bin=257 mag=152858709",
                     pq_cyc.size(), peak_bin, peak_mag);
        else begin
            n_pass++;
            n_total++;
            if (pq_cyc[0] != close_cyc + 3)
                $display("FAIL gapped_latency: got %0d want 3", pq_cyc[0] - close_cyc);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int close_a, close_b;
        clear_all();
        re_tab[10] = 100;
        send_beats(0, FRAME_LEN - 1, 100, close_a);
        for (int i = 0; i < FRAME_LEN; i++) begin
            re_tab[i] = 0;
            im_tab[i] = 0;
        end
        im_tab[20] = 300;
        send_beats(0, FRAME_LEN - 1, 100, close_b);
        step(8);
        n_total++;
        if (pq_cyc.size() != 2) $display("FAIL b2b_pulses: got %0d want 2", pq_cyc.size());
        else begin
            n_pass++;
            n_total++;
            if (pq_cyc[0] != close_a + 3 || pq_cyc[1] - pq_cyc[0] != 1024)
                $display("FAIL b2b_timing: got lat=%0d gap=%0d want lat=3 gap=1024",
                         pq_cyc[0] - close_a, pq_cyc[1] - pq_cyc[0]);
            else n_pass++;
            n_total++;
            if (pq_bin[0] !== 10'd10 || pq_mag[0] !== 65'd10000)
                $display("FAIL b2b_first: got bin=%0d mag=%0d want bin=10 mag=10000",
                         pq_bin[0], pq_mag[0]);
            else n_pass++;
            n_total++;
            if (pq_bin[1] !== 10'd20 || pq_mag[1] !== 65'd90000)
                $display("FAIL b2b_second: got bin=%0d mag=%0d want bin=20 mag=90000",
                         pq_bin[1], pq_mag[1]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int close_cyc;
        clear_all();
        re_tab[50] = 30000;
        send_beats(0, 599, 100, close_cyc);
        n_total++;
        if (busy !== 1'b1) $display("FAIL mid_busy: got %0b want 1", busy);
        else n_pass++;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_re    = 32'd30000;
        step(1);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_re    = '0;
        n_total++;
        if (busy !== 1'b0) $display("FAIL mid_busy_reset: got %0b want 0", busy);
        else n_pass++;
        re_tab[50] = 0;
        re_tab[77] = 7;
        send_beats(0, FRAME_LEN - 1, 100, close_cyc);
        step(8);
        n_total++;
        if (pq_cyc.size() != 1 || pq_bin[0] !== 10'd77 || pq_mag[0] !== 65'd49)
            $display("FAIL mid_reset: got n=%0d bin=%0d mag=%0d want n=1 bin=77 mag=49",
                     pq_cyc.size(), peak_bin, peak_mag);
        else n_pass++;
    endtask

    initial begin
        step(1);
        test_reset();
        test_single_tone();
        test_tie_range();
        test_extremes();
        test_gapped();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
